fft_delay_buf: RTL and testbench

Parametrised, frame-aware delay buffer for the FFT butterfly stages. It pairs each incoming parallel complex beat with the beat accepted D valid beats earlier in the same frame, and flags the cycles where that pair is valid for the butterfly. Unlike the fixed-depth pre-butterfly FIFO, the delay D is selected at run time per frame, lane count and depth are parameters, and pairing never crosses a frame boundary. It sits between each stage's input mux and its butterfly array.

---
 rtl/fft_delay_buf.sv | 117 +++++++++++
 tb/tb_fft_delay_buf.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fft_delay_buf.sv
// Frame-aware run-time-selectable delay line pairing each parallel complex beat
// with the beat accepted D beats earlier in the same frame, for a butterfly stage.

module fft_delay_lane #(
  parameter int DW    = 9,
  parameter int DEPTH = 16,
  parameter int DLW   = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_shift,
  input  logic [DLW-1:0] i_tap,
  input  logic [DW-1:0]  i_di,
  input  logic [DW-1:0]  i_dq,
  output logic [DW-1:0]  o_di,
  output logic [DW-1:0]  o_dq
);
  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0][DW-1:0] r_mem_i, r_mem_q;
  logic [IW-1:0]            w_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_i <= '0;
      r_mem_q <= '0;
    end else if (i_shift) begin
      r_mem_i[0] <= i_di;
      r_mem_q[0] <= i_dq;
      for (int j = 1; j < DEPTH; j++) begin
        r_mem_i[j] <= r_mem_i[j-1];
        r_mem_q[j] <= r_mem_q[j-1];
      end
    end
  end

  // Tap is always 1..DEPTH, so tap-1 fits the entry index.
  assign w_idx = IW'(i_tap - DLW'(1));
  assign o_di  = r_mem_i[w_idx];
  assign o_dq  = r_mem_q[w_idx];
endmodule

module fft_delay_buf #(
  parameter int DATA_WIDTH = 9,
  parameter int LANES      = 16,
  parameter int DEPTH      = 16,
  parameter int FRAME_LEN  = 32
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                clr,
  input  logic                                din_valid,
  input  logic signed [LANES-1:0][DATA_WIDTH-1:0] din_i,
  input  logic signed [LANES-1:0][DATA_WIDTH-1:0] din_q,
  input  logic [$clog2(DEPTH+1)-1:0]          cfg_delay,
  output logic signed [LANES-1:0][DATA_WIDTH-1:0] dout_i,
  output logic signed [LANES-1:0][DATA_WIDTH-1:0] dout_q,
  output logic                                bfly_en,
  output logic                                frame_done,
  output logic                                cfg_err
);
  localparam int DLW = $clog2(DEPTH+1);
  localparam int CW  = $clog2(FRAME_LEN);

  logic [CW-1:0]  r_beat_cnt;
  logic [DLW-1:0] r_d_act;
  logic           r_frame_done, r_cfg_err;

  logic           w_acc, w_start, w_last, w_cfg_bad;
  logic [DLW-1:0] w_d_load, w_d_eff;

  assign w_acc     = din_valid && !clr;
  assign w_start   = (r_beat_cnt == '0);
  assign w_last    = (r_beat_cnt == CW'(FRAME_LEN-1));
  assign w_cfg_bad = (cfg_delay == '0) || (cfg_delay > DLW'(DEPTH));
  assign w_d_load  = w_cfg_bad ? DLW'(DEPTH) : cfg_delay;
  // Frame-start beat uses the delay being latched this cycle.
  assign w_d_eff   = (w_acc && w_start) ? w_d_load : r_d_act;
  assign bfly_en   = w_acc && (32'(r_beat_cnt) >= 32'(w_d_eff));

  assign frame_done = r_frame_done;
  assign cfg_err    = r_cfg_err;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_beat_cnt   <= '0;
      r_d_act      <= DLW'(DEPTH);
      r_frame_done <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else if (clr) begin
      r_beat_cnt   <= '0;
      r_d_act      <= DLW'(DEPTH);
      r_frame_done <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_frame_done <= w_acc && w_last;
      if (w_acc) r_beat_cnt <= w_last ? '0 : r_beat_cnt + CW'(1);
      if (w_acc && w_start) begin
        r_d_act <= w_d_load;
        if (w_cfg_bad) r_cfg_err <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fft_delay_lane #(.DW(DATA_WIDTH), .DEPTH(DEPTH), .DLW(DLW)) u_lane (
      .clk     (clk),
      .rst     (rstn),
      .i_shift (w_acc),
      .i_tap   (w_d_eff),
      .i_di    (din_i[g]),
      .i_dq    (din_q[g]),
      .o_di    (dout_i[g]),
      .o_dq    (dout_q[g])
    );
  end
endmodule

// File: tb/tb_fft_delay_buf.sv
// Directed bench for fft_delay_buf: beats carry lane j = base+n+j (I) and its
// negation (Q), so the paired beat is recognisable by value.

module tb_fft_delay_buf;
  localparam int DW  = 9;
  localparam int L   = 16;
  localparam int DEP = 16;
  localparam int FL  = 32;
  localparam int DLW = $clog2(DEP+1);

  logic clk, rstn, clr, din_valid;
  logic signed [L-1:0][DW-1:0] din_i, din_q, dout_i, dout_q;
  logic [DLW-1:0] cfg_delay;
  logic bfly_en, frame_done, cfg_err;

  int  n_cmp = 0;
  int  n_err = 0;
  logic fd_exp = 1'b0;

  fft_delay_buf #(.DATA_WIDTH(DW), .LANES(L), .DEPTH(DEP), .FRAME_LEN(FL)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .din_valid(din_valid),
    .din_i(din_i), .din_q(din_q), .cfg_delay(cfg_delay),
    .dout_i(dout_i), .dout_q(dout_q), .bfly_en(bfly_en),
    .frame_done(frame_done), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [L-1:0][DW-1:0] bi(input int val);
    logic [L-1:0][DW-1:0] r;
    for (int j = 0; j < L; j++) r[j] = DW'(val + j);
    return r;
  endfunction

  function automatic logic [L-1:0][DW-1:0] bq(input int val);
    logic [L-1:0][DW-1:0] r;
    for (int j = 0; j < L; j++) r[j] = DW'(-(val + j));
    return r;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [L*DW-1:0] obs, input logic [L*DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic v, input logic c, input int cfg, input int val);
    din_valid = v;
    clr       = c;
    cfg_delay = DLW'(cfg);
    din_i     = bi(val);
    din_q     = bq(val);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle: drive, check combinational pairing and frame_done, clock.
  task automatic beat(input string tag, input logic v, input logic c, input int cfg,
                      input int val, input int idx, input logic exp_bf,
                      input logic chkd, input logic [L*DW-1:0] ei,
                      input logic [L*DW-1:0] eq);
    put(v, c, cfg, val);
    #3;
    chk1({tag, "_bfly"}, bfly_en, exp_bf);
    chk1({tag, "_fdone"}, frame_done, fd_exp);
    if (chkd) begin
      chkv({tag, "_dout_i"}, dout_i, ei);
      chkv({tag, "_dout_q"}, dout_q, eq);
    end
    tick();
    fd_exp = v && !c && (idx == FL-1);
  endtask

  task automatic frame(input string tag, input int base, input int cfg_a,
                       input int cfg_b, input int sw, input int d, input int max_gap);
    for (int n = 0; n < FL; n++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int k = 0; k < gap; k++)
        beat({tag, "_idle"}, 1'b0, 1'b0, cfg_b, 0, -1, 1'b0, 1'b0, '0, '0);
      beat(tag, 1'b1, 1'b0, (n < sw) ? cfg_a : cfg_b, base + n, n, (n >= d),
           (n >= d), bi(base + n - d), bq(base + n - d));
    end
  endtask

  initial begin
    rstn = 1'b1;
    put(1'b0, 1'b0, 16, 0);
    #2;
    chkv("rst_dout_i", dout_i, '0);
    chkv("rst_dout_q", dout_q, '0);
    chk1("rst_bfly", bfly_en, 1'b0);
    chk1("rst_fdone", frame_done, 1'b0);
    chk1("rst_err", cfg_err, 1'b0);
    tick();
    rstn = 1'b0;
    tick();

    // D=16, back-to-back into the following frames.
    frame("A_d16", 40, 16, 16, 0, 16, 0);
    // D=4 latched at beat 0; the change to 9 at beat 10 waits for the next frame.
    frame("B_d4", 80, 4, 9, 10, 4, 0);
    frame("C_d9", 120, 9, 9, 0, 9, 0);
    frame("D_gap", 10, 3, 3, 0, 3, 5);
    chk1("err_before_E", cfg_err, 1'b0);

    // Illegal delays fall back to DEPTH and set the sticky error.
    frame("E_d0", 60, 0, 0, 0, 16, 0);
    chk1("err_after_E", cfg_err, 1'b1);
    frame("F_d17", 100, 17, 17, 0, 16, 0);
    chk1("err_after_F", cfg_err, 1'b1);
    beat("clr_pulse", 1'b0, 1'b1, 17, 0, -1, 1'b0, 1'b0, '0, '0);
    chk1("err_after_clr", cfg_err, 1'b0);

    // Frame G (D=16 via cfg 0) cut by clr together with beat 20.
    for (int n = 0; n < 20; n++)
      beat("G", 1'b1, 1'b0, 0, 130 + n, n, (n >= 16), (n >= 16),
           bi(130 + n - 16), bq(130 + n - 16));
    chk1("err_G", cfg_err, 1'b1);
    beat("G_clr_beat", 1'b1, 1'b1, 0, 150, 20, 1'b0, 1'b0, '0, '0);
    chk1("err_after_G_clr", cfg_err, 1'b0);

    // New frame beat 0: tap 16 sees G beat 4 only if beat 20 was dropped.
    beat("H0", 1'b1, 1'b0, 20, 200, 0, 1'b0, 1'b1, bi(134), bq(134));
    chk1("err_H", cfg_err, 1'b1);
    for (int n = 1; n < 6; n++)
      beat("H", 1'b1, 1'b0, 20, 200 + n, n, 1'b0, 1'b0, '0, '0);

    // Asynchronous reset in the middle of a beat cycle.
    put(1'b1, 1'b0, 20, 206);
    #2;
    rstn = 1'b1;
    #1;
    chkv("mrst_dout_i", dout_i, '0);
    chkv("mrst_dout_q", dout_q, '0);
    chk1("mrst_bfly", bfly_en, 1'b0);
    chk1("mrst_fdone", frame_done, 1'b0);
    chk1("mrst_err", cfg_err, 1'b0);
    tick();
    rstn = 1'b0;
    fd_exp = 1'b0;

    // After release the next beat is beat 0; mem was zeroed.
    beat("J0", 1'b1, 1'b0, 2, 30, 0, 1'b0, 1'b1, '0, '0);
    beat("J1", 1'b1, 1'b0, 2, 31, 1, 1'b0, 1'b1, '0, '0);
    for (int n = 2; n < 6; n++)
      beat("J", 1'b1, 1'b0, 2, 30 + n, n, 1'b1, 1'b1, bi(30 + n - 2), bq(30 + n - 2));
    beat("end_idle", 1'b0, 1'b0, 2, 0, -1, 1'b0, 1'b0, '0, '0);
    chk1("err_end", cfg_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
